sramgen_sram_req_ctrl: RTL and testbench

Request front-end that sits directly upstream of the 2048x32, write-size-8 SRAM macro and drives its clk/we/wmask/addr/din pins. It accepts read and write requests on a valid/ready channel and registers them onto the macro pins. It captures the macro's synchronous dout two cycles after a read is accepted and returns read data in order through a credit-protected response FIFO with valid/ready backpressure. Writes produce no response.

---
 rtl/sramgen_sram_req_ctrl_if.sv | 29 ++
 rtl/sramgen_sram_req_ctrl.sv | 133 +++++++++++++
 tb/tb_sramgen_sram_req_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sramgen_sram_req_ctrl_if.sv
// Request/response channel of the SRAM request controller.
//   req_*  : valid/ready request channel (read or byte-masked write)
//   rsp_*  : valid/ready read-data return channel
// master = requester side, slave = controller side.
interface sramgen_sram_req_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int WMASK_WIDTH = 4
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sramgen_sram_req_ctrl.sv
// Front-end for a synchronous single-port SRAM macro with byte write mask.
// Requests are registered onto the macro pins (issue stage S1), the macro's
// dout is captured two edges after a read is accepted (S2) and returned in
// order through a credit-protected response FIFO.
// Ports:
//   clk, rst_n  : clock (shared with the macro), async active-low reset
//   bus (slave) : req_* request channel, rsp_* read response channel
//   sram_we/wmask/addr/din : registered macro inputs
//   sram_dout   : macro read data
module sramgen_sram_req_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int WMASK_WIDTH = 4,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sramgen_sram_req_ctrl_if.slave bus,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);

    generate
        if (DATA_WIDTH != 8 * WMASK_WIDTH || RSP_DEPTH < 3) begin : g_bad_cfg
            $error("sramgen_sram_req_ctrl: need DATA_WIDTH == 8*WMASK_WIDTH and RSP_DEPTH >= 3");
        end
    endgenerate

    // Two-flop release so req_ready only rises once reset is cleanly gone.
    logic [1:0] rst_sync;
    logic       rst_done;

    // Read tags: vld_pipe[0] = read sitting on the pins (S1),
    //            vld_pipe[1] = read whose dout is valid now (S2).
    logic [1:0] vld_pipe;
    logic [1:0] inflight;

    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic          accept, push, pop;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] rd_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rst_done  = rst_sync[1];
    assign inflight  = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]};
    // Credit check from registers only: every read in flight owns a FIFO slot.
    assign bus.req_ready = rst_done && ((int'(count) + int'(inflight)) < RSP_DEPTH);
    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_rdata = rdata_q;

    assign accept = bus.req_valid && bus.req_ready;
    assign push   = vld_pipe[1];
    assign pop    = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        cnt_nxt = count;
        if (push && !pop)
            cnt_nxt = count + CW'(1);
        else if (!push && pop)
            cnt_nxt = count - CW'(1);
        rd_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    // Issue stage: register the accepted request onto the macro pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_we    <= 1'b0;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
            vld_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept && !bus.req_we};
            if (accept) begin
                sram_addr  <= bus.req_addr;
                sram_we    <= bus.req_we;
                sram_wmask <= bus.req_we ? bus.req_wmask : '0;
                if (bus.req_we)
                    sram_din <= bus.req_wdata;
            end else begin
                // Idle cycle: macro does a harmless read that is never captured.
                sram_we    <= 1'b0;
                sram_wmask <= '0;
            end
        end
    end

    // Response FIFO. rdata_q is kept equal to the head entry so rsp_rdata
    // comes straight from a flop; when the FIFO is (or becomes) empty apart
    // from this cycle's push, the head is the captured dout itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            count  <= cnt_nxt;
            rd_ptr <= rd_nxt;
            if (push) begin
                mem[wr_ptr] <= sram_dout;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (cnt_nxt != '0) begin
                if (count == '0 || (pop && count == CW'(1)))
                    rdata_q <= sram_dout;
                else
                    rdata_q <= mem[rd_nxt];
            end
        end
    end
endmodule

// File: tb/tb_sramgen_sram_req_ctrl.sv
module tb_sramgen_sram_req_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int MW  = 4;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    sramgen_sram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

    sramgen_sram_req_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(DEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural macro: samples pins at posedge, dout registered.
    logic [DW-1:0] smem [2048];
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) smem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end
        sram_dout <= smem[sram_addr];
    end

    // Scoreboard state
    logic [DW-1:0] mdl [2048];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int n_rsp  = 0;
    int rdy_mode = 1;   // 0 low, 1 high, 2 random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every response handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got %h expected none", bus.rsp_rdata);
            end else begin
                chk("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // FIFO must never see a push when full without a simultaneous pop.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.vld_pipe[1] && int'(dut.count) == DEP && !(bus.rsp_valid && bus.rsp_ready)) begin
            errors++;
            $display("FAIL push_when_full got count %0d expected below %0d", dut.count, DEP);
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b0;
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Present one request until accepted. Reads push exp (or the model value
    // when use_mdl is set).
    task automatic send(input logic we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic use_mdl, input logic [DW-1:0] exp,
                        output int stalls);
        logic done;
        done   = 1'b0;
        stalls = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.req_we    = we;
            bus.req_wmask = m;
            bus.req_addr  = a;
            bus.req_wdata = d;
            @(negedge clk);
            if (bus.req_ready) begin
                done = 1'b1;
                if (we) begin
                    for (int b = 0; b < MW; b++)
                        if (m[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    exp_q.push_back(use_mdl ? mdl[a] : exp);
                end
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout got no accept expected accept addr %h", a);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    int st, cnt, acc, rsp0, stall_sum;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            smem[i] = '0;
            mdl[i]  = '0;
        end
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wmask = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_we", {31'd0, sram_we}, 32'd0);
        chk("rst_sram_wmask", {28'd0, sram_wmask}, 32'd0);
        chk("rst_sram_addr", {21'd0, sram_addr}, 32'd0);
        chk("rst_sram_din", sram_din, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 1;

        // Write then read with latency and we-pulse checks
        send(1'b1, 4'hF, 11'h005, 32'hDEADBEEF, 1'b0, '0, st);
        idle(0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sram_we) cnt++;
        end
        chk("we_pulse_len", cnt, 1);
        send(1'b0, 4'h0, 11'h005, '0, 1'b0, 32'hDEADBEEF, st);
        idle(0);
        @(negedge clk) chk("lat_e0", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk) chk("lat_e1", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk) chk("lat_e2", {31'd0, bus.rsp_valid}, 32'd1);
        idle(3);

        // Byte-masked overwrite at the top address
        send(1'b1, 4'hF, 11'h7FF, 32'h11223344, 1'b0, '0, st);
        send(1'b1, 4'b0101, 11'h7FF, 32'hAABBCCDD, 1'b0, '0, st);
        send(1'b0, 4'h0, 11'h7FF, '0, 1'b0, 32'h11BB33DD, st);
        idle(5);

        // Read-after-write back to back, no bubble
        send(1'b1, 4'hF, 11'h010, 32'hCAFEF00D, 1'b0, '0, st);
        send(1'b0, 4'h0, 11'h010, '0, 1'b0, 32'hCAFEF00D, st);
        chk("raw_no_bubble", st, 0);
        idle(5);

        // Credit limit with rsp_ready held low
        for (int i = 0; i < 10; i++)
            send(1'b1, 4'hF, AW'(i), 32'h10000000 + i, 1'b0, '0, st);
        idle(5);
        rdy_mode = 0;
        idle(2);
        rsp0 = n_rsp;
        acc  = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = AW'(acc);
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back(32'h10000000 + acc);
                acc++;
            end
        end
        chk("credit_accepts", acc, 4);
        chk("credit_ready_low", {31'd0, bus.req_ready}, 32'd0);
        rdy_mode = 1;
        for (int i = acc; i < 10; i++)
            send(1'b0, 4'h0, AW'(i), '0, 1'b0, 32'h10000000 + i, st);
        idle(8);
        chk("stream_rsp_count", n_rsp - rsp0, 10);
        chk("stream_q_empty", exp_q.size(), 0);

        // Reset with two reads in flight and two buffered
        rdy_mode = 0;
        idle(2);
        for (int i = 0; i < 4; i++)
            send(1'b0, 4'h0, AW'(i), '0, 1'b0, 32'h10000000 + i, st);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 1;
        rsp0 = n_rsp;
        repeat (10) @(posedge clk);
        chk("no_stale_rsp", n_rsp - rsp0, 0);
        send(1'b0, 4'h0, 11'h7FF, '0, 1'b0, 32'h11BB33DD, st);
        idle(6);
        chk("post_rst_rsp_count", n_rsp - rsp0, 1);

        // Random traffic against the model
        for (int i = 0; i < 2048; i++) mdl[i] = smem[i];
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++)
            send($urandom_range(1), MW'($urandom_range(15)), AW'($urandom_range(15)),
                 $urandom, 1'b1, '0, st);
        rdy_mode = 1;
        idle(12);
        chk("rand_q_empty", exp_q.size(), 0);

        // Full-rate window
        stall_sum = 0;
        for (int i = 0; i < 32; i++) begin
            send($urandom_range(1), MW'($urandom_range(15)), AW'($urandom_range(15)),
                 $urandom, 1'b1, '0, st);
            stall_sum += st;
        end
        idle(8);
        chk("full_rate_stalls", stall_sum, 0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
